// File: rtl/mul4_rr_scheduler.sv
// mul4_rr_scheduler
//
// Two requesters share one iterative 4x4 unsigned shift-add multiplier.
// A round-robin arbiter picks a request while the block is idle. The
// product is then built over four cycles with a single 4-bit add step
// per cycle, and held on the winner's response channel until it is taken.
//
// Ports
//   clock                        rising-edge clock
//   reset                        synchronous, active-high
//   io_req0_valid / _ready       port 0 request handshake
//   io_req0_a, io_req0_b         port 0 operands (4 bits each)
//   io_req1_*                    same as port 0, for port 1
//   io_resp0_valid / _ready      port 0 response handshake
//   io_resp0_result              product (8 bits), qualified by io_resp0_valid
//   io_resp1_*                   same as port 0, for port 1
//   io_busy                      high whenever the block is not idle
module mul4_rr_scheduler (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_req0_valid,
  output logic       io_req0_ready,
  input  logic [3:0] io_req0_a,
  input  logic [3:0] io_req0_b,
  input  logic       io_req1_valid,
  output logic       io_req1_ready,
  input  logic [3:0] io_req1_a,
  input  logic [3:0] io_req1_b,
  output logic       io_resp0_valid,
  input  logic       io_resp0_ready,
  output logic [7:0] io_resp0_result,
  output logic       io_resp1_valid,
  input  logic       io_resp1_ready,
  output logic [7:0] io_resp1_result,
  output logic       io_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] cnt;
  logic [7:0] acc;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       owner;
  logic       last;
  logic       resp0_valid_q;
  logic       resp1_valid_q;
  logic       busy_q;

  logic       grant;
  logic       req_fire;
  logic [3:0] partial;
  logic [4:0] sum;
  logic       owner_resp_ready;

  // Round-robin: a lone valid port wins; on a tie the port not granted
  // last time wins.
  always_comb begin
    // NOTE: default assignment first so no path leaves grant unassigned,
    // which would otherwise infer a latch.
    grant = 1'b0;
    if (io_req0_valid && io_req1_valid) grant = ~last;
    else if (io_req1_valid)             grant = 1'b1;
  end

  assign io_req0_ready = (state == IDLE) && io_req0_valid && !grant;
  assign io_req1_ready = (state == IDLE) && io_req1_valid &&  grant;
  assign req_fire      = io_req0_ready || io_req1_ready;

  // One shift-add step: add the selected partial product into the high
  // nibble; the 5-bit sum (with carry) then shifts right with the low bits.
  assign partial = b_q[cnt] ? a_q : 4'd0;
  assign sum     = {1'b0, acc[7:4]} + {1'b0, partial};

  // Only the owner's consumer can release the response.
  assign owner_resp_ready = owner ? io_resp1_ready : io_resp0_ready;

  always_ff @(posedge clock) begin
    // NOTE: every register, including the operand/accumulator datapath,
    // is reset so an operation interrupted by reset leaves no trace.
    if (reset) begin
      state         <= IDLE;
      cnt           <= 2'd0;
      acc           <= 8'd0;
      a_q           <= 4'd0;
      b_q           <= 4'd0;
      owner         <= 1'b0;
      last          <= 1'b1;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout: every register updates
      // from the values present before this edge.
      unique case (state)
        IDLE: begin
          if (req_fire) begin
            a_q    <= grant ? io_req1_a : io_req0_a;
            b_q    <= grant ? io_req1_b : io_req0_b;
            owner  <= grant;
            last   <= grant;
            acc    <= 8'd0;
            cnt    <= 2'd0;
            busy_q <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc <= {sum, acc[3:1]};
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state         <= DONE;
            resp0_valid_q <= ~owner;
            resp1_valid_q <=  owner;
          end
        end
        DONE: begin
          if (owner_resp_ready) begin
            state         <= IDLE;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            busy_q        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_resp0_valid  = resp0_valid_q;
  assign io_resp1_valid  = resp1_valid_q;
  assign io_resp0_result = acc;
  assign io_resp1_result = acc;
  assign io_busy         = busy_q;

endmodule

// File: tb/tb_mul4_rr_scheduler.sv
// Self-checking bench for mul4_rr_scheduler. Expected products are plain
// a*b; expected grants come from a one-bit "last granted" model applied to
// the set of ports holding a request.
module tb_mul4_rr_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_req0_valid, io_req0_ready;
  logic [3:0] io_req0_a, io_req0_b;
  logic       io_req1_valid, io_req1_ready;
  logic [3:0] io_req1_a, io_req1_b;
  logic       io_resp0_valid, io_resp0_ready;
  logic [7:0] io_resp0_result;
  logic       io_resp1_valid, io_resp1_ready;
  logic [7:0] io_resp1_result;
  logic       io_busy;

  int vectors    = 0;
  int miscompares = 0;
  int m_last     = 1;   // model: port granted most recently

  mul4_rr_scheduler dut (
    .clock(clock), .reset(reset),
    .io_req0_valid(io_req0_valid), .io_req0_ready(io_req0_ready),
    .io_req0_a(io_req0_a), .io_req0_b(io_req0_b),
    .io_req1_valid(io_req1_valid), .io_req1_ready(io_req1_ready),
    .io_req1_a(io_req1_a), .io_req1_b(io_req1_b),
    .io_resp0_valid(io_resp0_valid), .io_resp0_ready(io_resp0_ready),
    .io_resp0_result(io_resp0_result),
    .io_resp1_valid(io_resp1_valid), .io_resp1_ready(io_resp1_ready),
    .io_resp1_result(io_resp1_result),
    .io_busy(io_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [3:0] a, input logic [3:0] b);
    if (p == 0) begin io_req0_valid = v; io_req0_a = a; io_req0_b = b; end
    else        begin io_req1_valid = v; io_req1_a = a; io_req1_b = b; end
  endtask

  function automatic logic ready_of(input int p);
    return (p == 0) ? io_req0_ready : io_req1_ready;
  endfunction

  function automatic logic resp_valid_of(input int p);
    return (p == 0) ? io_resp0_valid : io_resp1_valid;
  endfunction

  function automatic logic [7:0] result_of(input int p);
    return (p == 0) ? io_resp0_result : io_resp1_result;
  endfunction

  function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
    return 8'(int'(a) * int'(b));
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    set_req(0, 1'b0, 4'd0, 4'd0);
    set_req(1, 1'b0, 4'd0, 4'd0);
    tick();
    tick();
    reset  = 1'b0;
    m_last = 1;
  endtask

  // Runs one request on port p (only port p requesting). Returns the
  // observed result, cycles from accept edge to first response valid, and
  // whether both handshakes happened within their budgets. Operands on the
  // bus are scrambled right after the accept edge.
  task automatic do_op(input int p, input logic [3:0] a, input logic [3:0] b, input int stall,
                       output logic [7:0] res, output int lat, output bit ok);
    bit got;
    ok = 1'b0; lat = 0; res = 8'd0; got = 1'b0;
    set_req(p, 1'b1, a, b);
    if (p == 0) begin io_resp0_ready = (stall == 0); io_resp1_ready = 1'($urandom); end
    else        begin io_resp1_ready = (stall == 0); io_resp0_ready = 1'($urandom); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (ready_of(p)) begin got = 1'b1; break; end
      tick();
    end
    if (!got) begin set_req(p, 1'b0, 4'd0, 4'd0); tick(); return; end
    tick();
    m_last = p;
    set_req(p, 1'b0, 4'($urandom), 4'($urandom));
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      lat++;
      if (resp_valid_of(p)) begin got = 1'b1; break; end
      tick();
    end
    if (!got) return;
    for (int i = 0; i < stall; i++) begin tick(); @(negedge clock); end
    if (p == 0) io_resp0_ready = 1'b1; else io_resp1_ready = 1'b1;
    res = result_of(p);
    tick();
    ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io_resp0_ready = 1'b0; io_resp1_ready = 1'b0;
    set_req(0, 1'b1, 4'd3, 4'd3);
    set_req(1, 1'b1, 4'd5, 4'd5);
    tick(); tick();
    @(negedge clock);
    vectors++; if (io_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", io_busy); end
    vectors++; if (io_resp0_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp0_valid: got %b want 0", io_resp0_valid); end
    vectors++; if (io_resp1_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp1_valid: got %b want 0", io_resp1_valid); end
    vectors++; if (io_resp0_result !== 8'd0) begin miscompares++; $display("FAIL rst_result0: got %0d want 0", io_resp0_result); end
    vectors++; if (io_resp1_result !== 8'd0) begin miscompares++; $display("FAIL rst_result1: got %0d want 0", io_resp1_result); end
    tick();
    set_req(0, 1'b0, 4'd0, 4'd0);
    set_req(1, 1'b0, 4'd0, 4'd0);
    reset = 1'b0; m_last = 1;
    @(negedge clock);
    vectors++; if (io_busy !== 1'b0) begin miscompares++; $display("FAIL rst_nothing_accepted: busy %b want 0", io_busy); end
    vectors++; if ({io_req0_ready, io_req1_ready} !== 2'b00) begin miscompares++; $display("FAIL idle_no_valid_ready: got %b want 00", {io_req0_ready, io_req1_ready}); end
    io_req1_valid = 1'b1;
    #1;
    vectors++; if ({io_req0_ready, io_req1_ready} !== 2'b01) begin miscompares++; $display("FAIL lone_port1_ready: got %b want 01", {io_req0_ready, io_req1_ready}); end
    io_req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_single();
    io_resp0_ready = 1'b1; io_resp1_ready = 1'b1;
    set_req(0, 1'b1, 4'd13, 4'd11);
    @(negedge clock);
    vectors++; if ({io_req0_ready, io_req1_ready} !== 2'b10) begin miscompares++; $display("FAIL single_accept: got %b want 10", {io_req0_ready, io_req1_ready}); end
    tick();
    m_last = 0;
    set_req(0, 1'b0, 4'd0, 4'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      vectors++; if (io_busy !== (k <= 5)) begin miscompares++; $display("FAIL single_busy T+%0d: got %b want %b", k, io_busy, (k <= 5)); end
      vectors++; if (io_resp0_valid !== (k == 5)) begin miscompares++; $display("FAIL single_resp0_valid T+%0d: got %b want %b", k, io_resp0_valid, (k == 5)); end
      vectors++; if (io_resp1_valid !== 1'b0) begin miscompares++; $display("FAIL single_resp1_valid T+%0d: got %b want 0", k, io_resp1_valid); end
      if (k == 5) begin
        vectors++; if (io_resp0_result !== 8'd143) begin miscompares++; $display("FAIL single_result: got %0d want 143", io_resp0_result); end
      end
      tick();
    end
  endtask

  task automatic test_tie();
    logic [3:0] a0, b0, a1, b1;
    int g;
    do_reset();
    io_resp0_ready = 1'b1; io_resp1_ready = 1'b1;
    set_req(0, 1'b1, 4'd15, 4'd15);
    set_req(1, 1'b1, 4'd7, 4'd9);
    @(negedge clock);
    g = (m_last == 1) ? 0 : 1;
    vectors++; if ({io_req1_ready, io_req0_ready} !== 2'(1 << g)) begin miscompares++; $display("FAIL tie1_grant: got r1r0=%b want port %0d", {io_req1_ready, io_req0_ready}, g); end
    tick(); m_last = 0;
    set_req(0, 1'b0, 4'd0, 4'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 5) begin
        vectors++; if (io_resp0_valid !== 1'b1 || io_resp0_result !== 8'd225) begin miscompares++; $display("FAIL tie_p0_result: valid %b result %0d want 1/225", io_resp0_valid, io_resp0_result); end
      end
      vectors++; if (io_req1_ready !== (k == 6)) begin miscompares++; $display("FAIL tie_p1_wait T+%0d: ready1 %b want %b", k, io_req1_ready, (k == 6)); end
      if (k < 6) tick();
    end
    tick(); m_last = 1;
    a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
    set_req(0, 1'b1, a0, b0);
    set_req(1, 1'b1, a1, b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 5) begin
        vectors++; if (io_resp1_valid !== 1'b1 || io_resp1_result !== 8'd63) begin miscompares++; $display("FAIL tie_p1_result: valid %b result %0d want 1/63", io_resp1_valid, io_resp1_result); end
      end
      g = (m_last == 1) ? 0 : 1;
      vectors++; if ({io_req1_ready, io_req0_ready} !== ((k == 6) ? 2'(1 << g) : 2'b00)) begin miscompares++; $display("FAIL tie2_grant T+%0d: got r1r0=%b", k, {io_req1_ready, io_req0_ready}); end
      if (k < 6) tick();
    end
    tick(); m_last = 0;
    set_req(0, 1'b0, 4'd0, 4'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 5) begin
        vectors++; if (io_resp0_valid !== 1'b1 || io_resp0_result !== prod(a0, b0)) begin miscompares++; $display("FAIL tie2_p0_result: valid %b result %0d want 1/%0d", io_resp0_valid, io_resp0_result, prod(a0, b0)); end
      end
      vectors++; if (io_req1_ready !== (k == 6)) begin miscompares++; $display("FAIL tie2_p1_wait T+%0d: ready1 %b", k, io_req1_ready); end
      if (k < 6) tick();
    end
    tick(); m_last = 1;
    set_req(1, 1'b0, 4'd0, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (k == 5) begin
        vectors++; if (io_resp1_valid !== 1'b1 || io_resp1_result !== prod(a1, b1)) begin miscompares++; $display("FAIL tie2_p1_result: valid %b result %0d want 1/%0d", io_resp1_valid, io_resp1_result, prod(a1, b1)); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    io_resp0_ready = 1'b1; io_resp1_ready = 1'b0;
    set_req(1, 1'b1, 4'd9, 4'd6);
    @(negedge clock);
    vectors++; if (io_req1_ready !== 1'b1) begin miscompares++; $display("FAIL bp_accept: ready1 %b want 1", io_req1_ready); end
    tick(); m_last = 1;
    set_req(1, 1'b0, 4'($urandom), 4'($urandom));
    set_req(0, 1'b1, 4'($urandom), 4'($urandom));
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      vectors++; if (io_req0_ready !== 1'b0) begin miscompares++; $display("FAIL bp_req0_held T+%0d: ready0 %b want 0", k, io_req0_ready); end
      vectors++; if (io_resp1_valid !== (k >= 5)) begin miscompares++; $display("FAIL bp_resp1_valid T+%0d: got %b want %b", k, io_resp1_valid, (k >= 5)); end
      if (k >= 5) begin
        vectors++; if (io_resp1_result !== 8'd54) begin miscompares++; $display("FAIL bp_result T+%0d: got %0d want 54", k, io_resp1_result); end
      end
      tick();
      if (k == 14) io_resp1_ready = 1'b1;
    end
    @(negedge clock);
    vectors++; if (io_busy !== 1'b0 || io_resp1_valid !== 1'b0) begin miscompares++; $display("FAIL bp_idle_after_fire: busy %b valid1 %b want 0/0", io_busy, io_resp1_valid); end
    vectors++; if (io_req0_ready !== 1'b1) begin miscompares++; $display("FAIL bp_req0_after: ready0 %b want 1", io_req0_ready); end
    set_req(0, 1'b0, 4'd0, 4'd0);
    tick();
  endtask

  task automatic test_operand_edges();
    logic [3:0] ea [5] = '{4'd0, 4'd15, 4'd1, 4'd8, 4'd15};
    logic [3:0] eb [5] = '{4'd15, 4'd0, 4'd1, 4'd8, 4'd1};
    logic [7:0] res;
    int lat;
    bit ok;
    int p;
    for (int i = 0; i < 5 + 256; i++) begin
      logic [3:0] a, b;
      if (i < 5) begin a = ea[i]; b = eb[i]; end
      else begin a = 4'((i - 5) >> 4); b = 4'(i - 5); end
      p = int'($urandom_range(0, 1));
      do_op(p, a, b, int'($urandom_range(0, 2)), res, lat, ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL op_handshake %0dx%0d port %0d: no accept/response within budget", a, b, p); end
      if (ok) begin
        vectors++; if (res !== prod(a, b)) begin miscompares++; $display("FAIL op_result %0dx%0d: got %0d want %0d", a, b, res, prod(a, b)); end
        vectors++; if (lat !== 5) begin miscompares++; $display("FAIL op_latency %0dx%0d: got %0d want 5", a, b, lat); end
      end
    end
  endtask

  task automatic test_operand_change();
    io_resp0_ready = 1'b1; io_resp1_ready = 1'b1;
    set_req(0, 1'b1, 4'd3, 4'd5);
    @(negedge clock);
    tick(); m_last = 0;
    io_req0_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      io_req0_a = 4'($urandom); io_req0_b = 4'($urandom);
      @(negedge clock);
      if (k == 5) begin
        vectors++; if (io_resp0_valid !== 1'b1 || io_resp0_result !== 8'd15) begin miscompares++; $display("FAIL opchg_result: valid %b result %0d want 1/15", io_resp0_valid, io_resp0_result); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    logic [3:0] a0, b0, a1, b1;
    io_resp0_ready = 1'b1; io_resp1_ready = 1'b1;
    set_req(0, 1'b1, 4'($urandom), 4'($urandom));
    @(negedge clock);
    tick(); m_last = 0;
    set_req(0, 1'b0, 4'd0, 4'd0);
    tick(); tick();
    reset = 1'b1;                      // cycle with cnt == 2
    @(negedge clock);
    vectors++; if (io_busy !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_busy: got %b want 1", io_busy); end
    tick();
    reset = 1'b0; m_last = 1;
    @(negedge clock);
    vectors++; if (io_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", io_busy); end
    vectors++; if ({io_resp0_valid, io_resp1_valid} !== 2'b00) begin miscompares++; $display("FAIL midrst_valid: got %b want 00", {io_resp0_valid, io_resp1_valid}); end
    vectors++; if (io_resp0_result !== 8'd0) begin miscompares++; $display("FAIL midrst_acc: got %0d want 0", io_resp0_result); end
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(); @(negedge clock);
      if (io_resp0_valid || io_resp1_valid) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL midrst_no_resp: response appeared after reset"); end
    tick();
    a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
    set_req(0, 1'b1, a0, b0);
    set_req(1, 1'b1, a1, b1);
    @(negedge clock);
    vectors++; if ({io_req1_ready, io_req0_ready} !== 2'b01) begin miscompares++; $display("FAIL midrst_tie: got r1r0=%b want 01", {io_req1_ready, io_req0_ready}); end
    tick(); m_last = 0;
    set_req(0, 1'b0, 4'd0, 4'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 5) begin
        vectors++; if (io_resp0_result !== prod(a0, b0) || io_resp0_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_p0_result: got %0d want %0d", io_resp0_result, prod(a0, b0)); end
      end
      if (k < 6) tick();
    end
    vectors++; if (io_req1_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_p1_accept: ready1 %b want 1", io_req1_ready); end
    tick(); m_last = 1;
    set_req(1, 1'b0, 4'd0, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (k == 5) begin
        vectors++; if (io_resp1_result !== prod(a1, b1) || io_resp1_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_p1_result: got %0d want %0d", io_resp1_result, prod(a1, b1)); end
      end
      tick();
    end
  endtask

  // Random contention: each idle slot, either port may raise a request;
  // a port that loses keeps its request pending until it wins.
  task automatic test_random_arb();
    bit         pend [2];
    logic [3:0] qa [2];
    logic [3:0] qb [2];
    int g;
    pend[0] = 1'b0; pend[1] = 1'b0;
    io_resp0_ready = 1'b1; io_resp1_ready = 1'b1;
    for (int it = 0; it < 40 || pend[0] || pend[1]; it++) begin
      if (it < 40) begin
        for (int p = 0; p < 2; p++) begin
          if (!pend[p] && $urandom_range(0, 1) == 1) begin
            pend[p] = 1'b1; qa[p] = 4'($urandom); qb[p] = 4'($urandom);
            set_req(p, 1'b1, qa[p], qb[p]);
          end
        end
        if (!pend[0] && !pend[1]) begin
          pend[0] = 1'b1; qa[0] = 4'($urandom); qb[0] = 4'($urandom);
          set_req(0, 1'b1, qa[0], qb[0]);
        end
      end
      g = (pend[0] && pend[1]) ? ((m_last == 1) ? 0 : 1) : (pend[1] ? 1 : 0);
      @(negedge clock);
      vectors++; if ({io_req1_ready, io_req0_ready} !== 2'(1 << g)) begin miscompares++; $display("FAIL rand_grant it%0d: got r1r0=%b want port %0d", it, {io_req1_ready, io_req0_ready}, g); end
      tick();
      m_last = g; pend[g] = 1'b0;
      set_req(g, 1'b0, 4'($urandom), 4'($urandom));
      for (int k = 1; k <= 5; k++) begin
        @(negedge clock);
        if (k == 5) begin
          vectors++; if (resp_valid_of(g) !== 1'b1 || result_of(g) !== prod(qa[g], qb[g])) begin miscompares++; $display("FAIL rand_result it%0d port %0d: valid %b got %0d want %0d", it, g, resp_valid_of(g), result_of(g), prod(qa[g], qb[g])); end
          vectors++; if (resp_valid_of(1 - g) !== 1'b0) begin miscompares++; $display("FAIL rand_other_valid it%0d: port %0d valid high", it, 1 - g); end
        end
        tick();
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    io_resp0_ready = 1'b0; io_resp1_ready = 1'b0;
    set_req(0, 1'b0, 4'd0, 4'd0);
    set_req(1, 1'b0, 4'd0, 4'd0);
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_operand_edges();
    test_operand_change();
    test_reset_mid();
    test_random_arb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
